// File: rtl/gray_pointer_receiver.sv
// Receive side of a Gray-coded pointer crossing: synchronizes the foreign pointer,
// decodes it to binary, reports advances/distance and flags illegal multi-bit steps.
module gray_pointer_receiver #(
  parameter int ADDR_LEN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_LEN-1:0] gray_in,
  input  logic                err_clear,
  output logic [ADDR_LEN-1:0] bin_out,
  output logic [ADDR_LEN-1:0] gray_sync,
  output logic                valid,
  output logic                advance,
  output logic [ADDR_LEN-1:0] delta,
  output logic                err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [ADDR_LEN-1:0] gray_to_bin(input logic [ADDR_LEN-1:0] g);
    logic [ADDR_LEN-1:0] b;
    b[ADDR_LEN-1] = g[ADDR_LEN-1];
    for (int i = ADDR_LEN - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic multi_bit_change(input logic [ADDR_LEN-1:0] d);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ADDR_LEN; i++) begin
      cnt = cnt + {31'b0, d[i]};
    end
    return (cnt > 32'sd1);
  endfunction

  logic [ADDR_LEN-1:0] sync_r [SYNC_STAGES];
  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    fill_cnt_r, fill_cnt_next_s;
  logic [ADDR_LEN-1:0] gray_prev_r, gray_prev_next_s;
  logic [ADDR_LEN-1:0] bin_next_s, delta_next_s, bin_dec_s;
  logic                advance_next_s, valid_next_s, err_set_s, err_next_s;

  assign gray_sync = sync_r[SYNC_STAGES-1];
  assign bin_dec_s = gray_to_bin(gray_sync);

  // Synchronizer chain for the asynchronous Gray pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {ADDR_LEN{1'b0}};
      end
    end else begin
      sync_r[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Next-state and next-output logic for FILL/TRACK.
  always_comb begin
    state_next_s     = state_r;
    fill_cnt_next_s  = fill_cnt_r;
    gray_prev_next_s = gray_prev_r;
    bin_next_s       = bin_out;
    valid_next_s     = valid;
    advance_next_s   = 1'b0;
    delta_next_s     = {ADDR_LEN{1'b0}};
    err_set_s        = 1'b0;
    case (state_r)
      FILL: begin
        bin_next_s       = bin_dec_s;
        gray_prev_next_s = gray_sync;
        if (fill_cnt_r == CNT_W'(SYNC_STAGES)) begin
          state_next_s = TRACK;
          valid_next_s = 1'b1;
        end else begin
          state_next_s    = FILL;
          fill_cnt_next_s = fill_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      TRACK: begin
        if (gray_sync != gray_prev_r) begin
          bin_next_s       = bin_dec_s;
          gray_prev_next_s = gray_sync;
          advance_next_s   = 1'b1;
          delta_next_s     = bin_dec_s - bin_out;
          err_set_s        = multi_bit_change(gray_sync ^ gray_prev_r);
        end else begin
          advance_next_s = 1'b0;
        end
      end
      default: begin
        state_next_s = FILL;
      end
    endcase
    // A fresh error outranks a simultaneous clear request.
    if (err_set_s) begin
      err_next_s = 1'b1;
    end else if (err_clear) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = err;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= FILL;
      fill_cnt_r  <= {CNT_W{1'b0}};
      gray_prev_r <= {ADDR_LEN{1'b0}};
      bin_out     <= {ADDR_LEN{1'b0}};
      valid       <= 1'b0;
      advance     <= 1'b0;
      delta       <= {ADDR_LEN{1'b0}};
      err         <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      fill_cnt_r  <= fill_cnt_next_s;
      gray_prev_r <= gray_prev_next_s;
      bin_out     <= bin_next_s;
      valid       <= valid_next_s;
      advance     <= advance_next_s;
      delta       <= delta_next_s;
      err         <= err_next_s;
    end
  end

endmodule

// File: tb/tb_gray_pointer_receiver.sv
// Directed bench for gray_pointer_receiver (ADDR_LEN=4, SYNC_STAGES=2); outputs are
// sampled 1 time unit after each rising edge, inputs are changed at the same point.
module tb_gray_pointer_receiver;

  logic       clk;
  logic       reset;
  logic [3:0] gray_in;
  logic       err_clear;
  logic [3:0] bin_out;
  logic [3:0] gray_sync;
  logic       valid;
  logic       advance;
  logic [3:0] delta;
  logic       err;

  int vectors;
  int miscompares;

  gray_pointer_receiver #(.ADDR_LEN(4), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .gray_in   (gray_in),
    .err_clear (err_clear),
    .bin_out   (bin_out),
    .gray_sync (gray_sync),
    .valid     (valid),
    .advance   (advance),
    .delta     (delta),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_bin, input logic e_valid,
                           input logic e_adv, input logic [3:0] e_delta, input logic e_err);
    check({tag, ".bin"},   32'(bin_out), 32'(e_bin));
    check({tag, ".valid"}, 32'(valid),   32'(e_valid));
    check({tag, ".adv"},   32'(advance), 32'(e_adv));
    check({tag, ".delta"}, 32'(delta),   32'(e_delta));
    check({tag, ".err"},   32'(err),     32'(e_err));
  endtask

  initial begin
    logic [3:0] g;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    gray_in     = 4'd0;
    err_clear   = 1'b0;

    // 1: reset and fill with gray_in = 0
    tick();
    tick();
    check_out("rst", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("rst.gsync", 32'(gray_sync), 32'd0);
    reset = 1'b0;
    tick();
    check_out("fill1", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check_out("fill2", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check_out("fill3", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    check_out("trk0", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

    // 2: Gray 1 with latency checks, then 3,2,6
    gray_in = 4'd1;
    tick();
    check_out("lat1", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    check("lat2.gsync", 32'(gray_sync), 32'd1);
    check_out("lat2", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    check_out("g1", 4'd1, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check_out("g1.end", 4'd1, 1'b1, 1'b0, 4'd0, 1'b0);
    gray_in = 4'd3; tick(); tick(); tick();
    check_out("g3", 4'd2, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check_out("g3.end", 4'd2, 1'b1, 1'b0, 4'd0, 1'b0);
    gray_in = 4'd2; tick(); tick(); tick();
    check_out("g2", 4'd3, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check_out("g2.end", 4'd3, 1'b1, 1'b0, 4'd0, 1'b0);
    gray_in = 4'd6; tick(); tick(); tick();
    check_out("g6", 4'd4, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check_out("g6.end", 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);

    // 3: count up through 15 (Gray 1000), then wrap to 0
    for (int i = 5; i < 16; i++) begin
      g = 4'(i ^ (i >> 1));
      gray_in = g; tick(); tick(); tick();
      check_out("cnt", 4'(i), 1'b1, 1'b1, 4'd1, 1'b0);
      tick();
      check("cnt.end.adv", 32'(advance), 32'd0);
    end
    check("top.gsync", 32'(gray_sync), 32'h8);
    gray_in = 4'd0; tick(); tick(); tick();
    check_out("wrap", 4'd0, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check_out("wrap.end", 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);

    // 4: illegal jump 0000 -> 0011, sticky err, set beats clear
    gray_in = 4'b0011; tick(); tick(); tick();
    check_out("jump1", 4'd2, 1'b1, 1'b1, 4'd2, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    check_out("sticky", 4'd2, 1'b1, 1'b0, 4'd0, 1'b1);
    gray_in = 4'b0110; tick(); tick();
    err_clear = 1'b1;
    tick();
    check_out("jump2", 4'd4, 1'b1, 1'b1, 4'd2, 1'b1);
    err_clear = 1'b0;
    tick();
    check_out("hold", 4'd4, 1'b1, 1'b0, 4'd0, 1'b1);
    err_clear = 1'b1;
    tick();
    check_out("clr", 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
    err_clear = 1'b0;
    tick();
    check("clr.stay", 32'(err), 32'd0);

    // 5: reach bin 5 (Gray 0111), reset mid-run, refill
    gray_in = 4'b0111; tick(); tick(); tick();
    check_out("b5", 4'd5, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_out("mrst", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    check("mrst.gsync", 32'(gray_sync), 32'd0);
    reset = 1'b0;
    tick();
    check_out("refill1", 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    check("refill2.valid", 32'(valid), 32'd0);
    check("refill2.adv", 32'(advance), 32'd0);
    tick();
    check_out("refill3", 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
    tick();
    check_out("refill4", 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);

    // 6: constant input for 20 cycles in TRACK
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle.adv", 32'(advance), 32'd0);
      check("idle.delta", 32'(delta), 32'd0);
      check("idle.bin", 32'(bin_out), 32'd5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
